// File: rtl/demux_pkg.sv
// Shared types and constants for the demux select sequencer.
package demux_pkg;

  localparam int unsigned NCH   = 8;
  localparam int unsigned SEL_W = $clog2(NCH);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/demux_sel_seq_if.sv
// Upstream bit handshake plus the demux-facing select/data strobe.
interface demux_sel_seq_if;
  import demux_pkg::*;

  logic             in_valid;
  logic             in_data;
  logic             in_ready;
  logic [SEL_W-1:0] sel;
  logic             d_out;
  logic             d_valid;

  modport master (
    output in_valid, in_data,
    input  in_ready, sel, d_out, d_valid
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, sel, d_out, d_valid
  );

endinterface

// File: rtl/demux_next_ch.sv
// Channel search over an enable mask: next enabled index above cur, and lowest enabled index.
module demux_next_ch
  import demux_pkg::*;
(
  input  logic [NCH-1:0]   mask_i,
  input  logic [SEL_W-1:0] cur_i,
  output logic [SEL_W-1:0] nxt_o,
  output logic             wrap_o,
  output logic [SEL_W-1:0] low_o
);

  // Descending scan so the last hit is the lowest qualifying index.
  always_comb begin : next_above
    nxt_o  = '0;
    wrap_o = 1'b1;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask_i[i] && (i > int'(cur_i))) begin
        nxt_o  = SEL_W'(i);
        wrap_o = 1'b0;
      end
    end
  end

  // Kept in its own block: the top feeds low_o back into cur_i.
  always_comb begin : lowest_set
    low_o = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask_i[i]) begin
        low_o = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/demux_sel_seq.sv
// Round-robin sequencer feeding a 1-to-NCH demux from a serial valid/ready bit stream.
module demux_sel_seq
  import demux_pkg::*;
#(
  parameter int unsigned FRAME_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [NCH-1:0]     ch_mask,
  demux_sel_seq_if.slave     bus,
  output logic               frame_done,
  output logic [FRAME_W-1:0] frame_cnt,
  output logic               busy
);

  state_t             state_q, state_d;
  logic [NCH-1:0]     mask_q, mask_d;
  logic [SEL_W-1:0]   cur_q, cur_d;
  logic               fresh_q, fresh_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               d_out_q, d_out_d;
  logic               d_valid_q, d_valid_d;
  logic               frame_done_q, frame_done_d;
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;

  logic [SEL_W-1:0]   eff_cur;
  logic [SEL_W-1:0]   nxt_ch;
  logic [SEL_W-1:0]   low_ch;
  logic               wrap;
  logic               accept;

  // fresh_q marks a newly loaded shadow mask whose first channel is its lowest set bit.
  assign eff_cur = fresh_q ? low_ch : cur_q;

  demux_next_ch u_next_ch (
    .mask_i (mask_q),
    .cur_i  (eff_cur),
    .nxt_o  (nxt_ch),
    .wrap_o (wrap),
    .low_o  (low_ch)
  );

  assign bus.in_ready = (state_q == RUN);
  assign busy         = (state_q == RUN);
  assign accept       = bus.in_valid & bus.in_ready;
  assign bus.sel      = sel_q;
  assign bus.d_out    = d_out_q;
  assign bus.d_valid  = d_valid_q;
  assign frame_done   = frame_done_q;
  assign frame_cnt    = frame_cnt_q;

  always_comb begin : next_state
    state_d      = state_q;
    mask_d       = mask_q;
    cur_d        = cur_q;
    fresh_d      = fresh_q;
    sel_d        = sel_q;
    d_out_d      = d_out_q;
    d_valid_d    = 1'b0;
    frame_done_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (start && !stop && (ch_mask != '0)) begin
          mask_d  = ch_mask;
          fresh_d = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (accept) begin
          d_valid_d = 1'b1;
          sel_d     = eff_cur;
          d_out_d   = bus.in_data;
          if (wrap) begin
            // Frame boundary: the only point where a live mask change is picked up.
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + FRAME_W'(1);
            mask_d       = ch_mask;
            fresh_d      = 1'b1;
            if (ch_mask == '0) begin
              state_d = IDLE;
            end
          end else begin
            cur_d   = nxt_ch;
            fresh_d = 1'b0;
          end
        end
        if (stop) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin : regs
    if (rst) begin
      state_q      <= IDLE;
      mask_q       <= '0;
      cur_q        <= '0;
      fresh_q      <= 1'b0;
      sel_q        <= '0;
      d_out_q      <= 1'b0;
      d_valid_q    <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      cur_q        <= cur_d;
      fresh_q      <= fresh_d;
      sel_q        <= sel_d;
      d_out_q      <= d_out_d;
      d_valid_q    <= d_valid_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

endmodule
